mips_timer: RTL and testbench

Programmable countdown timer on the CPU's peripheral bus, one slave behind the bridge that decodes the CPU's PrAddr/PrWD/PrWe. It raises one of the CPU's HWInt[7:2] lines.
- The bridge supplies the word-select, write enable and write data, and returns DOut on PrRD.
- Three word registers: CTRL (offset 0x0), PRESET (offset 0x4), COUNT (offset 0x8).
- Two modes: one-shot with a latched interrupt, and auto-reload with a one-cycle interrupt pulse.

---
 rtl/mips_timer.sv | 138 +++++++++++++
 tb/tb_mips_timer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_timer.sv
// Countdown timer slave on the CPU peripheral bus (CTRL/PRESET/COUNT), raising IRQ on expiry; prescaler under `TIMER_PRESCALE_EN.
// Latency: reads combinational; writes take effect at the next clk edge; IRQ asserts P+2 edges after enabling (P*PRESCALE_DIV+2 when prescaled).
// Backpressure: none; the bus never stalls, and every write is accepted in the cycle it is strobed.
module mips_timer #(
    parameter int unsigned PRESCALE_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        We,
    input  logic [31:0] DIn,
    output logic [31:0] DOut,
    output logic        IRQ
);

    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    state_t      state, state_nxt;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count, count_nxt;
    logic        pending;
    logic        pend_set, pend_clr, en_clr;
    logic        step;
    logic        wr_ctrl, wr_preset, auto_reload;

    assign wr_ctrl     = We && (Addr == 2'b00);
    assign wr_preset   = We && (Addr == 2'b01);
    assign auto_reload = (ctrl[2:1] == 2'b01);

`ifdef TIMER_PRESCALE_EN
    localparam logic [15:0] DIV_M1 = 16'(PRESCALE_DIV - 1);

    logic [15:0] presc, presc_nxt;

    assign step = (presc == DIV_M1);

    always_comb begin
        presc_nxt = presc;
        if (state == LOAD)
            presc_nxt = '0;
        else if (state == CNT && ctrl[0])
            presc_nxt = step ? '0 : presc + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            presc <= '0;
        else
            presc <= presc_nxt;
    end
`else
    logic [15:0] unused_div;

    assign unused_div = 16'(PRESCALE_DIV);
    assign step       = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        pend_set  = 1'b0;
        pend_clr  = 1'b0;
        en_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl[0])
                    state_nxt = LOAD;
            end
            LOAD: begin
                count_nxt = preset;
                state_nxt = CNT;
            end
            CNT: begin
                if (!ctrl[0]) begin
                    state_nxt = IDLE;
                end else if (step) begin
                    // Terminal at 1 or 0 so a zero PRESET never wraps COUNT.
                    if (count > 32'd1) begin
                        count_nxt = count - 32'd1;
                    end else begin
                        count_nxt = '0;
                        pend_set  = 1'b1;
                        state_nxt = INT;
                    end
                end
            end
            INT: begin
                if (auto_reload) begin
                    pend_clr  = 1'b1;
                    state_nxt = LOAD;
                end else begin
                    en_clr    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ctrl    <= '0;
            preset  <= '0;
            count   <= '0;
            pending <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            // A CPU write to CTRL overrides the one-shot Enable clear.
            if (wr_ctrl)
                ctrl <= DIn[3:0];
            else if (en_clr)
                ctrl[0] <= 1'b0;
            if (wr_preset)
                preset <= DIn;
            // Setting wins over a coincident bus clear so no interrupt is lost.
            if (pend_set)
                pending <= 1'b1;
            else if (wr_ctrl || wr_preset || pend_clr)
                pending <= 1'b0;
        end
    end

    always_comb begin
        DOut = '0;
        case (Addr)
            2'b00:   DOut = {28'b0, ctrl};
            2'b01:   DOut = preset;
            2'b10:   DOut = count;
            default: DOut = '0;
        endcase
    end

    assign IRQ = ctrl[3] & pending;

endmodule

// File: tb/tb_mips_timer.sv
// Scoreboarded bench for mips_timer: expectations queued at stimulus time, popped against DOut/IRQ.
module tb_mips_timer;

`ifdef TIMER_PRESCALE_EN
    localparam int DIV = 4;
`else
    localparam int DIV = 1;
`endif
    localparam int TERM6 = 2 + 2 * DIV;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  addr  = 2'b00;
    logic        we    = 1'b0;
    logic [31:0] din   = '0;
    logic [31:0] dout;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    mips_timer #(.PRESCALE_DIV(4)) dut (
        .clk  (clk),
        .reset(reset),
        .Addr (addr),
        .We   (we),
        .DIn  (din),
        .DOut (dout),
        .IRQ  (irq)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, need 0x%08h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic sb_pop(input logic [31:0] got);
        string       t;
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            chk(t, got, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a;
        din  = d;
        we   = 1'b1;
        tick();
        we   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        sb_push(tag, exp);
        addr = a;
        #1;
        sb_pop(dout);
    endtask

    task automatic irq_chk(input string tag, input logic exp);
        sb_push(tag, {31'b0, exp});
        sb_pop({31'b0, irq});
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        // 1: reset values, CTRL upper bits dropped, COUNT not writable
        #5;
        for (int a = 0; a < 4; a++)
            rd_chk($sformatf("t1_rst_dout_a%0d", a), 2'(a), 32'h0);
        irq_chk("t1_rst_irq", 1'b0);
        tick();
        reset = 1'b1;
        wr(2'b00, 32'hFFFF_FFFF);
        rd_chk("t1_ctrl_mask", 2'b00, 32'h0000_000F);
        wr(2'b10, 32'h0000_1234);
        rd_chk("t1_count_ro", 2'b10, 32'h0);

        // 2: one-shot, PRESET=5
        do_reset();
        wr(2'b01, 32'd5);
        wr(2'b00, 32'h9);
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k >= 2 && k <= 7)
                rd_chk($sformatf("t2_count_e%0d", k), 2'b10, 32'(7 - k));
            irq_chk($sformatf("t2_irq_e%0d", k), k >= 7);
            if (k >= 8)
                rd_chk($sformatf("t2_ctrl_e%0d", k), 2'b00, 32'h8);
        end
        wr(2'b00, 32'h8);
        irq_chk("t2_irq_ack", 1'b0);

        // 3: auto-reload, PRESET=3 -> one-cycle pulse every 5 edges
        do_reset();
        wr(2'b01, 32'd3);
        wr(2'b00, 32'hB);
        for (int k = 1; k <= 17; k++) begin
            tick();
            irq_chk($sformatf("t3_irq_e%0d", k), (k % 5) == 0);
        end
        rd_chk("t3_ctrl_en", 2'b00, 32'hB);

        // 4: disable mid-count freezes COUNT, re-enable reloads
        do_reset();
        wr(2'b01, 32'd10);
        wr(2'b00, 32'h9);
        for (int k = 1; k <= 5; k++)
            tick();
        wr(2'b00, 32'h8);
        for (int k = 0; k < 4; k++) begin
            tick();
            rd_chk($sformatf("t4_frozen_%0d", k), 2'b10, 32'd6);
            irq_chk($sformatf("t4_irq_%0d", k), 1'b0);
        end
        wr(2'b00, 32'h9);
        tick();
        rd_chk("t4_no_resume", 2'b10, 32'd6);
        tick();
        rd_chk("t4_reload", 2'b10, 32'd10);

        // 5: masked expiry, pending cleared by CTRL write, then unmasked run
        do_reset();
        wr(2'b01, 32'd2);
        wr(2'b00, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            irq_chk($sformatf("t5_masked_e%0d", k), 1'b0);
        end
        rd_chk("t5_ctrl_done", 2'b00, 32'h0);
        wr(2'b00, 32'h8);
        for (int k = 0; k < 3; k++) begin
            tick();
            irq_chk($sformatf("t5_cleared_%0d", k), 1'b0);
        end
        wr(2'b00, 32'h9);
        for (int k = 1; k <= 4; k++) begin
            tick();
            irq_chk($sformatf("t5_rerun_e%0d", k), k == 4);
        end

        // 6: asynchronous reset mid-count, then terminal latency
        do_reset();
        wr(2'b01, 32'd10);
        wr(2'b00, 32'h9);
        for (int k = 1; k <= 8; k++)
            tick();
        rd_chk("t6_count_pre", 2'b10, 32'd4);
        reset = 1'b0;
        #1;
        for (int a = 0; a < 4; a++)
            rd_chk($sformatf("t6_arst_a%0d", a), 2'(a), 32'h0);
        irq_chk("t6_arst_irq", 1'b0);
        tick();
        reset = 1'b1;
        wr(2'b01, 32'd2);
        wr(2'b00, 32'h9);
        for (int k = 1; k <= TERM6 + 1; k++) begin
            tick();
            irq_chk($sformatf("t6_term_e%0d", k), k >= TERM6);
        end

        // 7: coincident FSM set vs PRESET write, CPU CTRL write vs INT clear
        do_reset();
        wr(2'b01, 32'd2);
        wr(2'b00, 32'h9);
        for (int k = 1; k <= 3; k++)
            tick();
        wr(2'b01, 32'd7);
        irq_chk("t7_set_wins", 1'b1);
        wr(2'b00, 32'hB);
        rd_chk("t7_cpu_wins", 2'b00, 32'hB);
        irq_chk("t7_pending_clr", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
